// File: rtl/mem_rsp_pkg.sv
// Shared types and helpers for the memory responder: clear-engine state encoding and per-byte parity.
// Parity helper is used only when MEM_RSP_PARITY_EN is defined.
package mem_rsp_pkg;

   typedef enum logic [0:0] {
      RSP_IDLE,
      RSP_CLEAR
   } rsp_state_t;

   // Widest data word the parity helper supports; callers zero-extend and slice the result.
   localparam int PAR_MAX_DW = 1024;

   function automatic logic [PAR_MAX_DW/8-1:0] byte_parity(input logic [PAR_MAX_DW-1:0] d);
      logic [PAR_MAX_DW/8-1:0] p;
      p = '0;
      for (int b = 0; b < PAR_MAX_DW/8; b++) begin
         p[b] = ^d[b*8 +: 8];
      end
      return p;
   endfunction

endpackage

// File: rtl/rsp_delay_line.sv
// Valid+data shift pipeline of STAGES registers; STAGES=0 is a plain pass-through.
// Data registers are reset too, so the delivered data reads zero out of reset.
module rsp_delay_line #(
   parameter int STAGES = 7,
   parameter int DW     = 512
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          in_vld,
   input  logic [DW-1:0] in_data,
   output logic          out_vld,
   output logic [DW-1:0] out_data
);

   generate
      if (STAGES == 0) begin : g_pass
         assign out_vld  = in_vld;
         assign out_data = in_data;
      end else begin : g_pipe
         logic [STAGES-1:0] vld_q;
         logic [DW-1:0]     data_q [STAGES];

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               vld_q <= '0;
               for (int i = 0; i < STAGES; i++) begin
                  data_q[i] <= '0;
               end
            end else begin
               vld_q[0]  <= in_vld;
               data_q[0] <= in_data;
               for (int i = 1; i < STAGES; i++) begin
                  vld_q[i]  <= vld_q[i-1];
                  data_q[i] <= data_q[i-1];
               end
            end
         end

         assign out_vld  = vld_q[STAGES-1];
         assign out_data = data_q[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency scratchpad memory with a sequential clear engine, sticky error flags and request counters.
// Optional per-byte parity storage and checking is enabled with `define MEM_RSP_PARITY_EN.
module mem_responder
   import mem_rsp_pkg::*;
#(
   parameter int AW        = 16,
   parameter int DW        = 512,
   parameter int DEPTH     = 1024,
   parameter int MEM_DELAY = 8,
   parameter int CW        = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clr_pulse,
   input  logic [AW-1:0] raddr,
   input  logic          raddr_vld,
   output logic [DW-1:0] rdata,
   output logic          rdata_vld,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          wdata_vld,
   output logic          busy,
   output logic          err_oor,
   output logic          err_drop,
`ifdef MEM_RSP_PARITY_EN
   output logic          parity_err,
`endif
   output logic [CW-1:0] rd_cnt,
   output logic [CW-1:0] wr_cnt
);

   localparam int            AIW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   DEPTH_LIM = (AW+1)'(DEPTH);
   localparam logic [AIW-1:0] PTR_LAST = AIW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_MAX   = '1;

   logic [DW-1:0] mem [DEPTH];

   rsp_state_t     state_q, state_d;
   logic [AIW-1:0] ptr_q, ptr_d;

   logic           busy_eff;
   logic           rd_in_range, wr_in_range;
   logic           rd_acc, wr_acc, wr_hit;
   logic           drop_now, oor_now;
   logic [AIW-1:0] ridx, widx;

   logic           s1_vld;
   logic [DW-1:0]  s1_data;

   assign ridx = raddr[AIW-1:0];
   assign widx = waddr[AIW-1:0];

   // A clear request in the current cycle already counts as busy for incoming requests.
   assign busy        = (state_q == RSP_CLEAR);
   assign busy_eff    = busy | clr_pulse;
   assign rd_in_range = {1'b0, raddr} < DEPTH_LIM;
   assign wr_in_range = {1'b0, waddr} < DEPTH_LIM;
   assign rd_acc      = raddr_vld & ~busy_eff & rd_in_range;
   assign wr_acc      = wdata_vld & ~busy_eff & wr_in_range;
   assign wr_hit      = rd_acc & wr_acc & (ridx == widx);
   assign drop_now    = busy_eff & (raddr_vld | wdata_vld);
   assign oor_now     = (raddr_vld & ~rd_in_range) | (wdata_vld & ~wr_in_range);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RSP_IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Clear engine: one zero-write per cycle, restarting from word 0 on any new clear request.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         RSP_IDLE: begin
            if (clr_pulse) begin
               state_d = RSP_CLEAR;
               ptr_d   = '0;
            end
         end
         RSP_CLEAR: begin
            if (clr_pulse) begin
               ptr_d = '0;
            end else if (ptr_q == PTR_LAST) begin
               state_d = RSP_IDLE;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         default: state_d = RSP_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (busy) begin
         mem[ptr_q] <= '0;
      end else if (wr_acc) begin
         mem[widx] <= wdata;
      end
   end

   // Stage 1 samples the array in the request cycle; a same-address write wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_vld  <= 1'b0;
         s1_data <= '0;
      end else begin
         s1_vld  <= raddr_vld;
         s1_data <= rd_acc ? (wr_hit ? wdata : mem[ridx]) : '0;
      end
   end

   rsp_delay_line #(
      .STAGES (MEM_DELAY - 1),
      .DW     (DW)
   ) u_delay (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_vld   (s1_vld),
      .in_data  (s1_data),
      .out_vld  (rdata_vld),
      .out_data (rdata)
   );

   // A clear wipes flags and counters, but a request arriving alongside it still flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_oor  <= 1'b0;
         err_drop <= 1'b0;
         rd_cnt   <= '0;
         wr_cnt   <= '0;
      end else if (clr_pulse) begin
         err_oor  <= oor_now;
         err_drop <= drop_now;
         rd_cnt   <= '0;
         wr_cnt   <= '0;
      end else begin
         err_oor  <= err_oor | oor_now;
         err_drop <= err_drop | drop_now;
         if (rd_acc && rd_cnt != CNT_MAX) rd_cnt <= rd_cnt + 1'b1;
         if (wr_acc && wr_cnt != CNT_MAX) wr_cnt <= wr_cnt + 1'b1;
      end
   end

`ifdef MEM_RSP_PARITY_EN
   logic [DW/8-1:0]             par_mem [DEPTH];
   logic [PAR_MAX_DW/8-1:0]     wpar_full, rpar_full;
   logic                        par_bad;

   assign wpar_full = byte_parity(PAR_MAX_DW'(wdata));
   assign rpar_full = byte_parity(PAR_MAX_DW'(mem[ridx]));
   assign par_bad   = rd_acc & ~wr_hit & (rpar_full[DW/8-1:0] != par_mem[ridx]);

   always_ff @(posedge clk) begin
      if (busy) begin
         par_mem[ptr_q] <= '0;
      end else if (wr_acc) begin
         par_mem[widx] <= wpar_full[DW/8-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         parity_err <= 1'b0;
      end else if (clr_pulse) begin
         parity_err <= 1'b0;
      end else begin
         parity_err <= parity_err | par_bad;
      end
   end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus random traffic against a queue/array model.
module tb_mem_responder;

   localparam int DEPTH = 1024;
   localparam int DLY   = 8;
   localparam int DW    = 512;

   logic          clk;
   logic          reset_n;
   logic          clr_pulse;
   logic [15:0]   raddr;
   logic          raddr_vld;
   logic [DW-1:0] rdata;
   logic          rdata_vld;
   logic [15:0]   waddr;
   logic [DW-1:0] wdata;
   logic          wdata_vld;
   logic          busy;
   logic          err_oor;
   logic          err_drop;
   logic [15:0]   rd_cnt;
   logic [15:0]   wr_cnt;
`ifdef MEM_RSP_PARITY_EN
   logic          parity_err;
`endif

   mem_responder dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .clr_pulse  (clr_pulse),
      .raddr      (raddr),
      .raddr_vld  (raddr_vld),
      .rdata      (rdata),
      .rdata_vld  (rdata_vld),
      .waddr      (waddr),
      .wdata      (wdata),
      .wdata_vld  (wdata_vld),
      .busy       (busy),
      .err_oor    (err_oor),
      .err_drop   (err_drop),
`ifdef MEM_RSP_PARITY_EN
      .parity_err (parity_err),
`endif
      .rd_cnt     (rd_cnt),
      .wr_cnt     (wr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } rsp_t;

   logic [DW-1:0] model_mem [DEPTH];
   rsp_t          rsp_q [$];
   int            clear_left;
   bit            m_err_oor, m_err_drop;
   int            m_rd, m_wr;
   int            cyc;
   logic [DW-1:0] last_rdata;

   int num_checks;
   int num_fails;

   task automatic checkOutput(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
      num_checks++;
      if (actual !== expected) begin
         num_fails++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   function automatic logic [DW-1:0] randWord();
      logic [DW-1:0] d;
      for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom();
      return d;
   endfunction

   // One clock cycle: drive at the falling edge, update the model, then check after the next falling edge.
   task automatic applyStimulus(input bit rv, input int ra, input bit wv, input int wa,
                                input logic [DW-1:0] wd, input bit clr);
      bit   eff, r_in, w_in, r_ok, w_ok, drop, oor, exp_v;
      rsp_t r;
      raddr_vld = rv;
      raddr     = ra[15:0];
      wdata_vld = wv;
      waddr     = wa[15:0];
      wdata     = wd;
      clr_pulse = clr;

      eff  = (clear_left > 0) || clr;
      r_in = ra < DEPTH;
      w_in = wa < DEPTH;
      r_ok = rv && !eff && r_in;
      w_ok = wv && !eff && w_in;
      if (rv) begin
         r.due  = cyc + DLY;
         r.data = r_ok ? ((w_ok && wa == ra) ? wd : model_mem[ra]) : '0;
         rsp_q.push_back(r);
      end
      if (w_ok) model_mem[wa] = wd;
      drop = eff && (rv || wv);
      oor  = (rv && !r_in) || (wv && !w_in);
      if (clr) begin
         m_err_oor  = oor;
         m_err_drop = drop;
         m_rd       = 0;
         m_wr       = 0;
         clear_left = DEPTH;
         for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      end else begin
         m_err_oor  = m_err_oor | oor;
         m_err_drop = m_err_drop | drop;
         if (r_ok && m_rd < 65535) m_rd++;
         if (w_ok && m_wr < 65535) m_wr++;
         if (clear_left > 0) clear_left--;
      end

      @(posedge clk);
      @(negedge clk);
      cyc++;

      exp_v = (rsp_q.size() > 0) && (rsp_q[0].due <= cyc);
      checkOutput("rdata_vld", DW'(rdata_vld), DW'(exp_v));
      if (exp_v) begin
         checkOutput("rdata", rdata, rsp_q[0].data);
         void'(rsp_q.pop_front());
      end
      if (rdata_vld) last_rdata = rdata;
      checkOutput("busy", DW'(busy), DW'(clear_left > 0));
      checkOutput("err_oor", DW'(err_oor), DW'(m_err_oor));
      checkOutput("err_drop", DW'(err_drop), DW'(m_err_drop));
      checkOutput("rd_cnt", DW'(rd_cnt), DW'(m_rd));
      checkOutput("wr_cnt", DW'(wr_cnt), DW'(m_wr));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, '0, 0);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_rdata"}, rdata, '0);
      checkOutput({tag, "_rdata_vld"}, DW'(rdata_vld), '0);
      checkOutput({tag, "_busy"}, DW'(busy), '0);
      checkOutput({tag, "_err_oor"}, DW'(err_oor), '0);
      checkOutput({tag, "_err_drop"}, DW'(err_drop), '0);
      checkOutput({tag, "_rd_cnt"}, DW'(rd_cnt), '0);
      checkOutput({tag, "_wr_cnt"}, DW'(wr_cnt), '0);
   endtask

   initial begin
      logic [DW-1:0] pat;
      num_checks = 0;
      num_fails  = 0;
      cyc        = 0;
      clear_left = 0;
      m_err_oor  = 0;
      m_err_drop = 0;
      m_rd       = 0;
      m_wr       = 0;
      last_rdata = '0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

      reset_n   = 1'b0;
      clr_pulse = 1'b0;
      raddr_vld = 1'b0;
      raddr     = '0;
      wdata_vld = 1'b0;
      waddr     = '0;
      wdata     = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResetValues("reset");
      reset_n = 1'b1;

      // Known-zero array to start from.
      applyStimulus(0, 0, 0, 0, '0, 1);
      idle(DEPTH + 2);

      $display("[TB] write then read addr 3");
      applyStimulus(0, 0, 1, 3, {64{8'hA5}}, 0);
      applyStimulus(1, 3, 0, 0, '0, 0);
      idle(DLY + 2);
      checkOutput("a5_data", last_rdata, {64{8'hA5}});
      checkOutput("a5_rd_cnt", DW'(rd_cnt), DW'(1));
      checkOutput("a5_wr_cnt", DW'(wr_cnt), DW'(1));

      $display("[TB] write-first same address");
      applyStimulus(0, 0, 1, 7, {64{8'h22}}, 0);
      applyStimulus(1, 7, 1, 7, {64{8'h11}}, 0);
      idle(DLY + 2);
      checkOutput("wfirst_data", last_rdata, {64{8'h11}});

      $display("[TB] back-to-back reads 0..15");
      for (int i = 0; i < 16; i++) begin
         pat = randWord();
         applyStimulus(0, 0, 1, i, pat, 0);
      end
      for (int i = 0; i < 16; i++) applyStimulus(1, i, 0, 0, '0, 0);
      idle(DLY + 2);

      $display("[TB] out-of-range access");
      applyStimulus(1, 1024, 1, 2000, {64{8'h5A}}, 0);
      idle(DLY + 2);
      checkOutput("oor_flag", DW'(err_oor), DW'(1));
      checkOutput("oor_data", last_rdata, '0);

      $display("[TB] clear with read during busy");
      applyStimulus(0, 0, 0, 0, '0, 1);
      idle(2);
      applyStimulus(1, 5, 0, 0, '0, 0);
      idle(DEPTH);
      checkOutput("clr_drop", DW'(err_drop), DW'(1));
      checkOutput("clr_rdata", last_rdata, '0);
      checkOutput("clr_done", DW'(busy), '0);
      last_rdata = '1;
      applyStimulus(1, 5, 0, 0, '0, 0);
      idle(DLY + 2);
      checkOutput("clr_word5", last_rdata, '0);

      $display("[TB] random traffic");
      for (int i = 0; i < 1500; i++) begin
         int ra, wa;
         ra = ($urandom_range(0, 15) == 0) ? $urandom_range(DEPTH, 2047) : $urandom_range(0, 31);
         wa = ($urandom_range(0, 15) == 0) ? $urandom_range(DEPTH, 2047) : $urandom_range(0, 31);
         applyStimulus($urandom_range(0, 1), ra, $urandom_range(0, 1), wa, randWord(), (i == 600));
      end
      idle(DEPTH + DLY + 2);

      $display("[TB] reset with reads in flight");
      applyStimulus(0, 0, 1, 9, {64{8'h3C}}, 0);
      for (int i = 0; i < 4; i++) applyStimulus(1, 9, 0, 0, '0, 0);
      reset_n = 1'b0;
      #2;
      checkResetValues("rst_async");
      rsp_q.delete();
      m_err_oor  = 0;
      m_err_drop = 0;
      m_rd       = 0;
      m_wr       = 0;
      clear_left = 0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      idle(DLY + 4);
      checkResetValues("rst_after");

      $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fails);
      $finish;
   end

endmodule
